pipe_mem_access: RTL and testbench

- EX/MEM pipeline register plus data-memory access controller; sits directly downstream of the execute stage.
- Latches the EX result bundle (ALU result, store data, destination register, control bits).
- Drives a request/acknowledge data-memory port and stalls the upstream pipeline until the access completes.
- Presents the MEM-stage outputs to the MEM/WB register.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/mem_timeout_cnt.sv | 29 ++
 rtl/pipe_mem_access.sv | 129 ++++++++++++
 tb/tb_pipe_mem_access.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types and widths for the EX/MEM pipeline register and data-memory access path.
package pipe_pkg;

    localparam int DATA_W = 32;
    localparam int RN_W   = 5;
    localparam int TO_W   = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// Watchdog counter for a data-memory access: cleared on BUSY entry, counts unacked BUSY cycles.
module mem_timeout_cnt
    import pipe_pkg::*;
(
    input  logic            clock,
    input  logic            resetn,
    input  logic            clr,
    input  logic            en,
    input  logic [TO_W-1:0] limit,
    output logic            expire
);

    logic [TO_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Fires on the cycle whose edge would bring the count up to the limit.
    assign expire = en && (({1'b0, cnt} + 9'd1) == {1'b0, limit});

endmodule

// File: rtl/pipe_mem_access.sv
// EX/MEM pipeline register plus request/acknowledge data-memory controller.
// Optional watchdog timeout enabled by defining PIPE_MEM_TIMEOUT_EN.
module pipe_mem_access
    import pipe_pkg::*;
#(
    parameter int TO_CYCLES = 16
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              ewreg,
    input  logic              em2reg,
    input  logic              ewmem,
    input  logic [DATA_W-1:0] ealu,
    input  logic [DATA_W-1:0] eb,
    input  logic [RN_W-1:0]   ern,
    output logic              mwreg,
    output logic              mm2reg,
    output logic [DATA_W-1:0] malu,
    output logic [DATA_W-1:0] mmo,
    output logic [RN_W-1:0]   mrn,
    output logic              mem_stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              mem_err
);

    state_t            state, state_nxt;
    logic              mwreg_q, mm2reg_q, mwmem_q;
    logic [DATA_W-1:0] eb_q, mmo_q;
    logic              busy, mem_op, capture, load_done, to_expire;

    assign busy      = (state == BUSY);
    assign mem_op    = em2reg | ewmem;
    assign capture   = ~mem_stall;
    assign load_done = busy & dmem_ack & mm2reg_q;

`ifdef PIPE_MEM_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TO_CYCLES);
    logic mem_err_q;

    mem_timeout_cnt u_timeout (
        .clock  (clock),
        .resetn (resetn),
        .clr    (capture & mem_op),
        .en     (busy & ~dmem_ack),
        .limit  (TO_LIMIT),
        .expire (to_expire)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mem_err_q <= 1'b0;
        end else if (to_expire) begin
            mem_err_q <= 1'b1;
        end
    end

    assign mem_err = mem_err_q;
`else
    localparam int unused_to_cycles = TO_CYCLES;
    assign to_expire = 1'b0;
    assign mem_err   = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A new memory op captured on the ack edge keeps the port busy with no idle gap.
    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            IDLE: if (capture && mem_op) state_nxt = BUSY;
            BUSY: begin
                if (dmem_ack)       state_nxt = mem_op ? BUSY : IDLE;
                else if (to_expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every pipeline flop is reset; there is no array storage here to exempt.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            mwreg_q  <= 1'b0;
            mm2reg_q <= 1'b0;
            mwmem_q  <= 1'b0;
            malu     <= '0;
            mrn      <= '0;
            eb_q     <= '0;
            mmo_q    <= '0;
        end else begin
            if (capture) begin
                mwreg_q  <= ewreg;
                mm2reg_q <= em2reg;
                mwmem_q  <= ewmem;
                malu     <= ealu;
                mrn      <= ern;
                eb_q     <= eb;
            end else if (to_expire) begin
                mwreg_q  <= 1'b0;
            end
            if (load_done) begin
                mmo_q <= dmem_rdata;
            end
        end
    end

    always_comb begin
        mem_stall  = busy & ~dmem_ack;
        dmem_req   = busy;
        dmem_we    = mwmem_q;
        dmem_addr  = malu;
        dmem_wdata = eb_q;
        mm2reg     = mm2reg_q;
        mwreg      = mwreg_q & ~mem_stall;
        mmo        = load_done ? dmem_rdata : mmo_q;
    end

endmodule

// File: tb/tb_pipe_mem_access.sv
// Directed self-checking bench for pipe_mem_access (timeout cases under PIPE_MEM_TIMEOUT_EN).
module tb_pipe_mem_access;
    import pipe_pkg::*;

    logic              clock = 1'b0;
    logic              resetn;
    logic              ewreg, em2reg, ewmem;
    logic [DATA_W-1:0] ealu, eb;
    logic [RN_W-1:0]   ern;
    logic              mwreg, mm2reg;
    logic [DATA_W-1:0] malu, mmo;
    logic [RN_W-1:0]   mrn;
    logic              mem_stall, dmem_req, dmem_we;
    logic [DATA_W-1:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic              dmem_ack, mem_err;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_mem_access #(.TO_CYCLES(4)) dut (
        .clock      (clock),
        .resetn     (resetn),
        .ewreg      (ewreg),
        .em2reg     (em2reg),
        .ewmem      (ewmem),
        .ealu       (ealu),
        .eb         (eb),
        .ern        (ern),
        .mwreg      (mwreg),
        .mm2reg     (mm2reg),
        .malu       (malu),
        .mmo        (mmo),
        .mrn        (mrn),
        .mem_stall  (mem_stall),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_rdata (dmem_rdata),
        .dmem_ack   (dmem_ack),
        .mem_err    (mem_err)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic set_e(input logic w, input logic l, input logic s,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        ewreg = w; em2reg = l; ewmem = s; ealu = a; eb = b; ern = r;
    endtask

    // Inputs change at the falling edge; outputs are sampled 1 time unit later.
    task automatic cyc();
        @(negedge clock);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, ".mwreg"},  32'(mwreg), 0);
        check({pfx, ".mm2reg"}, 32'(mm2reg), 0);
        check({pfx, ".malu"},   malu, 0);
        check({pfx, ".mmo"},    mmo, 0);
        check({pfx, ".mrn"},    32'(mrn), 0);
        check({pfx, ".stall"},  32'(mem_stall), 0);
        check({pfx, ".req"},    32'(dmem_req), 0);
        check({pfx, ".we"},     32'(dmem_we), 0);
        check({pfx, ".addr"},   dmem_addr, 0);
        check({pfx, ".wdata"},  dmem_wdata, 0);
        check({pfx, ".err"},    32'(mem_err), 0);
    endtask

    initial begin
        // Reset with random inputs and a spurious ack
        resetn = 1'b0;
        set_e(1'b1, 1'b1, 1'b1, $urandom, $urandom, 5'($urandom));
        dmem_ack = 1'b1; dmem_rdata = $urandom;
        repeat (2) cyc();
        #1 check_all_zero("rst");
        cyc();
        resetn = 1'b1;
        #1 check_all_zero("rst_rel");
        set_e(0, 0, 0, 0, 0, 0); dmem_ack = 1'b0; dmem_rdata = '0;

        // ALU op
        cyc(); set_e(1, 0, 0, 32'h0000_1234, 0, 7);
        cyc(); set_e(0, 0, 0, 0, 0, 0);
        #1;
        check("alu.malu",  malu, 32'h1234);
        check("alu.mrn",   32'(mrn), 7);
        check("alu.mwreg", 32'(mwreg), 1);
        check("alu.stall", 32'(mem_stall), 0);
        check("alu.req",   32'(dmem_req), 0);

        // Load, acked in the 3rd BUSY cycle
        cyc(); set_e(1, 1, 0, 32'h100, 0, 3);
        for (int i = 0; i < 2; i++) begin
            cyc(); #1;
            check($sformatf("ld%0d.stall", i), 32'(mem_stall), 1);
            check($sformatf("ld%0d.mwreg", i), 32'(mwreg), 0);
            check($sformatf("ld%0d.req", i),   32'(dmem_req), 1);
            check($sformatf("ld%0d.we", i),    32'(dmem_we), 0);
            check($sformatf("ld%0d.addr", i),  dmem_addr, 32'h100);
        end
        cyc(); set_e(0, 0, 0, 0, 0, 0); dmem_ack = 1'b1; dmem_rdata = 32'hDEAD_BEEF;
        #1;
        check("ld.mmo",   mmo, 32'hDEAD_BEEF);
        check("ld.mwreg", 32'(mwreg), 1);
        check("ld.stall", 32'(mem_stall), 0);
        check("ld.mm2reg", 32'(mm2reg), 1);
        cyc(); dmem_ack = 1'b0; dmem_rdata = 32'h5555_5555;
        #1;
        check("ld_after.req", 32'(dmem_req), 0);
        check("ld_after.mmo", mmo, 32'hDEAD_BEEF);

        // Ack while idle is ignored
        cyc(); dmem_ack = 1'b1;
        #1 check("idle_ack.mmo", mmo, 32'hDEAD_BEEF);
        cyc(); dmem_ack = 1'b0;
        #1 check("idle_ack.req", 32'(dmem_req), 0);

        // Zero-wait store to an unaligned address
        cyc(); set_e(0, 0, 1, 32'h203, 32'hA5A5_A5A5, 0);
        cyc(); set_e(0, 0, 0, 0, 0, 0); dmem_ack = 1'b1;
        #1;
        check("st.req",   32'(dmem_req), 1);
        check("st.we",    32'(dmem_we), 1);
        check("st.addr",  dmem_addr, 32'h203);
        check("st.wdata", dmem_wdata, 32'hA5A5_A5A5);
        check("st.stall", 32'(mem_stall), 0);
        check("st.mwreg", 32'(mwreg), 0);
        cyc(); dmem_ack = 1'b0;
        #1 check("st_after.req", 32'(dmem_req), 0);

        // Back-to-back loads, one wait each
        cyc(); set_e(1, 1, 0, 32'h10, 0, 1);
        cyc(); set_e(1, 1, 0, 32'h14, 0, 2);
        #1;
        check("b2b0.stall", 32'(mem_stall), 1);
        check("b2b0.addr",  dmem_addr, 32'h10);
        cyc(); dmem_ack = 1'b1; dmem_rdata = 32'h1111_0000;
        #1;
        check("b2b1.mmo",   mmo, 32'h1111_0000);
        check("b2b1.mwreg", 32'(mwreg), 1);
        check("b2b1.mrn",   32'(mrn), 1);
        cyc(); set_e(0, 0, 0, 0, 0, 0); dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        check("b2b2.req",   32'(dmem_req), 1);
        check("b2b2.addr",  dmem_addr, 32'h14);
        check("b2b2.stall", 32'(mem_stall), 1);
        check("b2b2.mmo",   mmo, 32'h1111_0000);
        check("b2b2.mrn",   32'(mrn), 2);
        cyc(); dmem_ack = 1'b1; dmem_rdata = 32'h2222_0000;
        #1;
        check("b2b3.mmo",   mmo, 32'h2222_0000);
        check("b2b3.mwreg", 32'(mwreg), 1);
        cyc(); dmem_ack = 1'b0; dmem_rdata = '0;
        #1;
        check("b2b4.req", 32'(dmem_req), 0);
        check("b2b4.mmo", mmo, 32'h2222_0000);

`ifdef PIPE_MEM_TIMEOUT_EN
        // Load that is never acked
        cyc(); set_e(1, 1, 0, 32'h300, 0, 4);
        for (int i = 0; i < 4; i++) begin
            cyc(); #1;
            check($sformatf("to%0d.stall", i), 32'(mem_stall), 1);
            check($sformatf("to%0d.err", i),   32'(mem_err), 0);
        end
        cyc(); set_e(0, 0, 0, 0, 0, 0);
        #1;
        check("to.stall", 32'(mem_stall), 0);
        check("to.err",   32'(mem_err), 1);
        check("to.mwreg", 32'(mwreg), 0);
        check("to.req",   32'(dmem_req), 0);
        check("to.mmo",   mmo, 32'h2222_0000);
        repeat (3) cyc();
        #1 check("to.err_sticky", 32'(mem_err), 1);
`endif

        // Reset asserted mid-BUSY drops the request at once
        cyc(); set_e(1, 1, 0, 32'h400, 0, 5);
        cyc(); set_e(0, 0, 0, 0, 0, 0);
        #1 check("rst_busy.req_before", 32'(dmem_req), 1);
        #1 resetn = 1'b0;
        #1;
        check("rst_busy.req", 32'(dmem_req), 0);
        check("rst_busy.err", 32'(mem_err), 0);
        check("rst_busy.malu", malu, 0);
        cyc(); resetn = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
